// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: coin credit, per-product price and stock,
// and change returned as one greedy coin per cycle.
//
//   state    | meaning
//   ---------+-------------------------------------------
//   S_IDLE   | no credit held; restock allowed
//   S_CREDIT | credit > 0; waiting for coin/select/cancel
//   S_VEND   | one-cycle dispense pulse (Z)
//   S_CHANGE | one change coin per cycle until credit = 0
module vending_machine_multi #(
    parameter int NUM_PRODUCTS = 4,
    parameter int SEL_W        = 2,
    parameter int CREDIT_W     = 8,
    parameter int CREDIT_MAX   = 200,
    parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES = {8'd60, 8'd30, 8'd50, 8'd40},
    parameter int STOCK_W      = 4,
    parameter int STOCK_INIT   = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    coin_valid,
    input  logic [1:0]              coin,
    input  logic                    sel_valid,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    cancel,
    input  logic                    restock_valid,
    input  logic [SEL_W-1:0]        restock_id,
    output logic                    Z,
    output logic [SEL_W-1:0]        vend_id,
    output logic                    Change_given,
    output logic [7:0]              Change_out,
    output logic [CREDIT_W-1:0]     credit,
    output logic                    busy,
    output logic                    coin_reject,
    output logic                    sel_reject,
    output logic [NUM_PRODUCTS-1:0] sold_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    localparam logic [CREDIT_W:0]  CMAX  = (CREDIT_W+1)'(CREDIT_MAX);
    localparam logic [SEL_W:0]     NPROD = (SEL_W+1)'(NUM_PRODUCTS);
    localparam logic [STOCK_W-1:0] SINIT = STOCK_W'(STOCK_INIT);

    state_t               r_state, w_state_nxt;
    logic [CREDIT_W-1:0]  r_credit, w_credit_nxt;
    logic [STOCK_W-1:0]   r_stock     [NUM_PRODUCTS];
    logic [STOCK_W-1:0]   w_stock_nxt [NUM_PRODUCTS];
    logic [SEL_W-1:0]     r_vend_id, w_vend_id_nxt;
    logic                 r_coin_reject, w_coin_reject_nxt;
    logic                 r_sel_reject, w_sel_reject_nxt;

    logic [CREDIT_W-1:0]  w_coin_val;
    logic [CREDIT_W:0]    w_coin_sum;
    logic                 w_coin_ok;
    logic                 w_sel_in_range;
    logic [CREDIT_W-1:0]  w_price;
    logic                 w_sel_ok;
    logic                 w_restock_in_range;
    logic [CREDIT_W-1:0]  w_change_coin;
    logic [7:0]           w_change_code;
    logic                 w_req_taken;

    always_comb begin
        w_coin_val = '0;
        case (coin)
            2'b00:   w_coin_val = CREDIT_W'(10);
            2'b01:   w_coin_val = CREDIT_W'(20);
            2'b10:   w_coin_val = CREDIT_W'(50);
            default: w_coin_val = '0;
        endcase
    end

    assign w_coin_sum = {1'b0, r_credit} + {1'b0, w_coin_val};
    assign w_coin_ok  = (coin != 2'b11) && (w_coin_sum <= CMAX);

    assign w_sel_in_range     = ({1'b0, sel} < NPROD);
    assign w_restock_in_range = ({1'b0, restock_id} < NPROD);
    assign w_price            = PRICES[sel*CREDIT_W +: CREDIT_W];
    assign w_sel_ok           = w_sel_in_range && (r_stock[sel] != '0) && (r_credit >= w_price);

    // Greedy refund: credit is always a nonzero multiple of 10 while in S_CHANGE.
    always_comb begin
        w_change_coin = CREDIT_W'(10);
        w_change_code = 8'd10;
        if (r_credit >= CREDIT_W'(50)) begin
            w_change_coin = CREDIT_W'(50);
            w_change_code = 8'd50;
        end else if (r_credit >= CREDIT_W'(20)) begin
            w_change_coin = CREDIT_W'(20);
            w_change_code = 8'd20;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_credit_nxt      = r_credit;
        w_stock_nxt       = r_stock;
        w_vend_id_nxt     = r_vend_id;
        w_coin_reject_nxt = 1'b0;
        w_sel_reject_nxt  = 1'b0;
        w_req_taken       = 1'b0;

        case (r_state)
            S_IDLE, S_CREDIT: begin
                if (cancel && (r_state == S_CREDIT)) begin
                    w_req_taken = 1'b1;
                    w_state_nxt = S_CHANGE;
                end else if (sel_valid) begin
                    if ((r_state == S_CREDIT) && w_sel_ok) begin
                        w_req_taken      = 1'b1;
                        w_credit_nxt     = r_credit - w_price;
                        w_stock_nxt[sel] = r_stock[sel] - STOCK_W'(1);
                        w_vend_id_nxt    = sel;
                        w_state_nxt      = S_VEND;
                    end else begin
                        w_sel_reject_nxt = 1'b1;
                    end
                end

                if (coin_valid) begin
                    if (w_req_taken || !w_coin_ok) begin
                        w_coin_reject_nxt = 1'b1;
                    end else begin
                        w_credit_nxt = w_coin_sum[CREDIT_W-1:0];
                        w_state_nxt  = S_CREDIT;
                    end
                end

                if ((r_state == S_IDLE) && restock_valid && w_restock_in_range) begin
                    w_stock_nxt[restock_id] = SINIT;
                end
            end

            S_VEND: begin
                w_coin_reject_nxt = coin_valid;
                w_state_nxt       = (r_credit != '0) ? S_CHANGE : S_IDLE;
            end

            S_CHANGE: begin
                w_coin_reject_nxt = coin_valid;
                w_credit_nxt      = r_credit - w_change_coin;
                if (w_credit_nxt == '0) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt  = S_IDLE;
                w_credit_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= S_IDLE;
            r_credit      <= '0;
            r_vend_id     <= '0;
            r_coin_reject <= 1'b0;
            r_sel_reject  <= 1'b0;
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                r_stock[i] <= SINIT;
            end
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_vend_id     <= w_vend_id_nxt;
            r_coin_reject <= w_coin_reject_nxt;
            r_sel_reject  <= w_sel_reject_nxt;
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                r_stock[i] <= w_stock_nxt[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PRODUCTS; i++) begin
            sold_out[i] = (r_stock[i] == '0);
        end
    end

    assign Z            = (r_state == S_VEND);
    assign vend_id      = r_vend_id;
    assign Change_given = (r_state == S_CHANGE);
    assign Change_out   = (r_state == S_CHANGE) ? w_change_code : 8'd0;
    assign credit       = r_credit;
    assign busy         = (r_state == S_VEND) || (r_state == S_CHANGE);
    assign coin_reject  = r_coin_reject;
    assign sel_reject   = r_sel_reject;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: scenario tasks plus a change/vend scoreboard
// fed by the tasks and drained by a monitor on the falling clock edge.
module tb_vending_machine_multi;

    localparam logic [1:0] C10  = 2'b00;
    localparam logic [1:0] C20  = 2'b01;
    localparam logic [1:0] C50  = 2'b10;
    localparam logic [1:0] CBAD = 2'b11;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] sel = 2'b00;
    logic       cancel = 1'b0;
    logic       restock_valid = 1'b0;
    logic [1:0] restock_id = 2'b00;

    logic       Z;
    logic [1:0] vend_id;
    logic       Change_given;
    logic [7:0] Change_out;
    logic [7:0] credit;
    logic       busy;
    logic       coin_reject;
    logic       sel_reject;
    logic [3:0] sold_out;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_coin_q[$];
    int exp_vend_q[$];
    int mon_e;

    always #5 CLK = ~CLK;

    vending_machine_multi #(
        .NUM_PRODUCTS(4),
        .SEL_W(2),
        .CREDIT_W(8),
        .CREDIT_MAX(200),
        .PRICES({8'd60, 8'd30, 8'd50, 8'd40}),
        .STOCK_W(4),
        .STOCK_INIT(1)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .coin_valid(coin_valid),
        .coin(coin),
        .sel_valid(sel_valid),
        .sel(sel),
        .cancel(cancel),
        .restock_valid(restock_valid),
        .restock_id(restock_id),
        .Z(Z),
        .vend_id(vend_id),
        .Change_given(Change_given),
        .Change_out(Change_out),
        .credit(credit),
        .busy(busy),
        .coin_reject(coin_reject),
        .sel_reject(sel_reject),
        .sold_out(sold_out)
    );

    // Scoreboard: every emitted change coin and vend must match the queued expectation.
    always @(negedge CLK) begin
        if (Change_given === 1'b1) begin
            n_cmp++;
            if (exp_coin_q.size() == 0) begin
                n_bad++;
                $display("FAIL change_coin: got unexpected coin %0d, required none", Change_out);
            end else begin
                mon_e = exp_coin_q.pop_front();
                if (Change_out !== 8'(mon_e)) begin
                    n_bad++;
                    $display("FAIL change_coin: got %0d required %0d", Change_out, mon_e);
                end
            end
        end
        if (Z === 1'b1) begin
            n_cmp++;
            if (exp_vend_q.size() == 0) begin
                n_bad++;
                $display("FAIL vend: got unexpected vend of %0d, required none", vend_id);
            end else begin
                mon_e = exp_vend_q.pop_front();
                if (vend_id !== 2'(mon_e)) begin
                    n_bad++;
                    $display("FAIL vend_id: got %0d required %0d", vend_id, mon_e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_coin(input logic [1:0] c);
        coin_valid = 1'b1;
        coin       = c;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic drive_sel(input logic [1:0] s);
        sel_valid = 1'b1;
        sel       = s;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic drive_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic drive_restock(input logic [1:0] id);
        restock_valid = 1'b1;
        restock_id    = id;
        tick();
        restock_valid = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (credit !== 8'd0 || Change_out !== 8'd0 || vend_id !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_values: credit=%0d change_out=%0d vend_id=%0d required 0/0/0", credit, Change_out, vend_id);
        end
        n_cmp++;
        if ({Z, busy, Change_given, coin_reject, sel_reject} !== 5'b0 || sold_out !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_flags: flags=%b sold_out=%b required 00000/0000",
                     {Z, busy, Change_given, coin_reject, sel_reject}, sold_out);
        end
        RESET = 1'b0;
    endtask

    task automatic test_exact_vend();
        drive_coin(C20);
        n_cmp++;
        if (credit !== 8'd20) begin n_bad++; $display("FAIL exact_credit1: credit=%0d required 20", credit); end
        drive_coin(C20);
        n_cmp++;
        if (credit !== 8'd40) begin n_bad++; $display("FAIL exact_credit2: credit=%0d required 40", credit); end
        exp_vend_q.push_back(0);
        drive_sel(2'd0);
        n_cmp++;
        if (Z !== 1'b1 || credit !== 8'd0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL exact_vend: Z=%b credit=%0d busy=%b required 1/0/1", Z, credit, busy);
        end
        n_cmp++;
        if (sold_out !== 4'b0001) begin n_bad++; $display("FAIL exact_sold_out: sold_out=%b required 0001", sold_out); end
        tick();
        n_cmp++;
        if (Z !== 1'b0 || busy !== 1'b0 || Change_given !== 1'b0 || credit !== 8'd0) begin
            n_bad++;
            $display("FAIL exact_idle: Z=%b busy=%b change=%b credit=%0d required 0/0/0/0", Z, busy, Change_given, credit);
        end
        drive_restock(2'd0);
        n_cmp++;
        if (sold_out !== 4'b0000) begin n_bad++; $display("FAIL exact_restock: sold_out=%b required 0000", sold_out); end
    endtask

    task automatic test_change();
        drive_coin(C50);
        drive_coin(C50);
        n_cmp++;
        if (credit !== 8'd100) begin n_bad++; $display("FAIL change_credit: credit=%0d required 100", credit); end
        exp_vend_q.push_back(2);
        exp_coin_q.push_back(50);
        exp_coin_q.push_back(20);
        drive_sel(2'd2);
        n_cmp++;
        if (Z !== 1'b1 || credit !== 8'd70) begin n_bad++; $display("FAIL change_vend: Z=%b credit=%0d required 1/70", Z, credit); end
        tick();
        n_cmp++;
        if (Change_out !== 8'd50 || credit !== 8'd70 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL change_first: out=%0d credit=%0d busy=%b required 50/70/1", Change_out, credit, busy);
        end
        tick();
        n_cmp++;
        if (Change_out !== 8'd20 || credit !== 8'd20) begin
            n_bad++;
            $display("FAIL change_second: out=%0d credit=%0d required 20/20", Change_out, credit);
        end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || credit !== 8'd0 || Change_given !== 1'b0) begin
            n_bad++;
            $display("FAIL change_done: busy=%b credit=%0d change=%b required 0/0/0", busy, credit, Change_given);
        end
        n_cmp++;
        if (exp_coin_q.size() != 0) begin n_bad++; $display("FAIL change_count: %0d coins missing, required 0", exp_coin_q.size()); end
        drive_restock(2'd2);
    endtask

    task automatic test_cancel();
        drive_coin(C10);
        drive_coin(C20);
        n_cmp++;
        if (credit !== 8'd30) begin n_bad++; $display("FAIL cancel_credit: credit=%0d required 30", credit); end
        exp_coin_q.push_back(20);
        exp_coin_q.push_back(10);
        cancel     = 1'b1;
        coin_valid = 1'b1;
        coin       = C50;
        tick();
        cancel     = 1'b0;
        coin_valid = 1'b0;
        n_cmp++;
        if (coin_reject !== 1'b1 || credit !== 8'd30 || Change_given !== 1'b1) begin
            n_bad++;
            $display("FAIL cancel_priority: coin_reject=%b credit=%0d change=%b required 1/30/1", coin_reject, credit, Change_given);
        end
        tick();
        n_cmp++;
        if (credit !== 8'd10 || Z !== 1'b0) begin n_bad++; $display("FAIL cancel_mid: credit=%0d Z=%b required 10/0", credit, Z); end
        tick();
        n_cmp++;
        if (busy !== 1'b0 || credit !== 8'd0 || exp_coin_q.size() != 0) begin
            n_bad++;
            $display("FAIL cancel_done: busy=%b credit=%0d pending=%0d required 0/0/0", busy, credit, exp_coin_q.size());
        end
    endtask

    task automatic test_sold_out();
        drive_coin(C50);
        exp_vend_q.push_back(1);
        drive_sel(2'd1);
        n_cmp++;
        if (Z !== 1'b1 || credit !== 8'd0) begin n_bad++; $display("FAIL sold_vend: Z=%b credit=%0d required 1/0", Z, credit); end
        tick();
        drive_coin(C50);
        drive_sel(2'd1);
        n_cmp++;
        if (sel_reject !== 1'b1 || Z !== 1'b0 || credit !== 8'd50) begin
            n_bad++;
            $display("FAIL sold_reject: sel_reject=%b Z=%b credit=%0d required 1/0/50", sel_reject, Z, credit);
        end
        n_cmp++;
        if (sold_out !== 4'b0010) begin n_bad++; $display("FAIL sold_flag: sold_out=%b required 0010", sold_out); end
        exp_coin_q.push_back(50);
        drive_cancel();
        tick();
        drive_restock(2'd1);
        n_cmp++;
        if (sold_out !== 4'b0000 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL sold_restock: sold_out=%b busy=%b required 0000/0", sold_out, busy);
        end
    endtask

    task automatic test_overflow();
        drive_coin(C50);
        drive_coin(C50);
        drive_coin(C50);
        drive_coin(C20);
        drive_coin(C10);
        n_cmp++;
        if (credit !== 8'd180) begin n_bad++; $display("FAIL ovf_credit: credit=%0d required 180", credit); end
        drive_coin(C50);
        n_cmp++;
        if (coin_reject !== 1'b1 || credit !== 8'd180) begin
            n_bad++;
            $display("FAIL ovf_reject: coin_reject=%b credit=%0d required 1/180", coin_reject, credit);
        end
        tick();
        n_cmp++;
        if (coin_reject !== 1'b0) begin n_bad++; $display("FAIL ovf_pulse: coin_reject=%b required 0", coin_reject); end
        drive_coin(CBAD);
        n_cmp++;
        if (coin_reject !== 1'b1 || credit !== 8'd180) begin
            n_bad++;
            $display("FAIL bad_code: coin_reject=%b credit=%0d required 1/180", coin_reject, credit);
        end
        drive_coin(C20);
        n_cmp++;
        if (coin_reject !== 1'b0 || credit !== 8'd200) begin
            n_bad++;
            $display("FAIL ovf_max: coin_reject=%b credit=%0d required 0/200", coin_reject, credit);
        end
        drive_coin(C10);
        n_cmp++;
        if (coin_reject !== 1'b1 || credit !== 8'd200) begin
            n_bad++;
            $display("FAIL ovf_full: coin_reject=%b credit=%0d required 1/200", coin_reject, credit);
        end
        for (int i = 0; i < 4; i++) exp_coin_q.push_back(50);
        drive_cancel();
        for (int i = 0; i < 12 && busy === 1'b1; i++) tick();
        n_cmp++;
        if (busy !== 1'b0 || credit !== 8'd0 || exp_coin_q.size() != 0) begin
            n_bad++;
            $display("FAIL ovf_drain: busy=%b credit=%0d pending=%0d required 0/0/0", busy, credit, exp_coin_q.size());
        end
    endtask

    task automatic test_sel_reject();
        drive_sel(2'd3);
        n_cmp++;
        if (sel_reject !== 1'b1 || credit !== 8'd0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL sel_idle: sel_reject=%b credit=%0d busy=%b required 1/0/0", sel_reject, credit, busy);
        end
        drive_coin(C10);
        drive_sel(2'd3);
        n_cmp++;
        if (sel_reject !== 1'b1 || credit !== 8'd10 || Z !== 1'b0) begin
            n_bad++;
            $display("FAIL sel_short: sel_reject=%b credit=%0d Z=%b required 1/10/0", sel_reject, credit, Z);
        end
        exp_coin_q.push_back(10);
        drive_cancel();
        for (int i = 0; i < 12 && busy === 1'b1; i++) tick();
        n_cmp++;
        if (busy !== 1'b0 || exp_coin_q.size() != 0) begin
            n_bad++;
            $display("FAIL sel_drain: busy=%b pending=%0d required 0/0", busy, exp_coin_q.size());
        end
    endtask

    task automatic test_change_coin_reset();
        drive_coin(C50);
        drive_coin(C20);
        drive_coin(C10);
        exp_coin_q.push_back(50);
        exp_coin_q.push_back(20);
        exp_coin_q.push_back(10);
        drive_cancel();
        n_cmp++;
        if (Change_out !== 8'd50 || credit !== 8'd80) begin
            n_bad++;
            $display("FAIL rst_first: out=%0d credit=%0d required 50/80", Change_out, credit);
        end
        drive_coin(C10);
        n_cmp++;
        if (coin_reject !== 1'b1 || credit !== 8'd30 || Change_out !== 8'd20) begin
            n_bad++;
            $display("FAIL change_coin_rej: coin_reject=%b credit=%0d out=%0d required 1/30/20", coin_reject, credit, Change_out);
        end
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        n_cmp++;
        if (Change_given !== 1'b0 || credit !== 8'd0 || busy !== 1'b0 || Change_out !== 8'd0) begin
            n_bad++;
            $display("FAIL rst_mid_change: change=%b credit=%0d busy=%b out=%0d required 0/0/0/0",
                     Change_given, credit, busy, Change_out);
        end
        n_cmp++;
        if (exp_coin_q.size() != 1) begin n_bad++; $display("FAIL rst_coins: pending=%0d required 1", exp_coin_q.size()); end
        exp_coin_q.delete();
        tick();
        n_cmp++;
        if (Change_given !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_after: change=%b busy=%b required 0/0", Change_given, busy);
        end
    endtask

    initial begin
        test_reset();
        test_exact_vend();
        test_change();
        test_cancel();
        test_sold_out();
        test_overflow();
        test_sel_reject();
        test_change_coin_reset();
        tick();
        n_cmp++;
        if (exp_vend_q.size() != 0) begin n_bad++; $display("FAIL vend_count: %0d vends missing, required 0", exp_vend_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vending_machine_multi.md
# vending_machine_multi

Parametrised multi-product successor to the single-product Sprite vending FSM. It accumulates coin credit across cycles and vends one of `NUM_PRODUCTS` items, each with its own price. It tracks per-product stock and returns change or a cancelled credit as a multi-cycle sequence of individual coins. It sits between the coin acceptor / keypad front end and the dispenser / coin-hopper drivers.

## Interface
Parameters:
- `NUM_PRODUCTS`, 4: number of selectable products.
- `SEL_W`, 2: width of `sel` and `vend_id`; must satisfy 2^`SEL_W` >= `NUM_PRODUCTS`.
- `CREDIT_W`, 8: width of credit and of each price field.
- `CREDIT_MAX`, 200: maximum credit held. Must be a multiple of 10 and < 2^`CREDIT_W`.
- `PRICES`, {8'd60,8'd30,8'd50,8'd40}: packed prices, `NUM_PRODUCTS`×`CREDIT_W` bits. Product i occupies bits [i*`CREDIT_W` +: `CREDIT_W`], so defaults are p0=40, p1=50, p2=30, p3=60. Every price is a nonzero multiple of 10 and <= `CREDIT_MAX`.
- `STOCK_W`, 4: width of each stock counter.
- `STOCK_INIT`, 8: stock loaded for every product on reset and on restock.

Ports:
- `CLK` in 1: clock; all state changes on its rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `coin_valid` in 1: a coin is presented this cycle.
- `coin` in 2: coin code. 00=10, 01=20, 10=50, 11=invalid.
- `sel_valid` in 1: a product selection is presented this cycle.
- `sel` in `SEL_W`: selected product index.
- `cancel` in 1: request a refund of the whole credit.
- `restock_valid` in 1: reload one product's stock counter to `STOCK_INIT`.
- `restock_id` in `SEL_W`: index of the product to restock.
- `Z` out 1: vend pulse; product is out.
- `vend_id` out `SEL_W`: product being vended; meaningful only while `Z`=1.
- `Change_given` out 1: one change coin is emitted this cycle.
- `Change_out` out 8: value of that coin in decimal (10/20/50); 0 when `Change_given`=0.
- `credit` out `CREDIT_W`: current credit.
- `busy` out 1: high in VEND and CHANGE.
- `coin_reject` out 1: one-cycle pulse; the previous cycle's coin was returned and not credited.
- `sel_reject` out 1: one-cycle pulse; the previous cycle's selection was refused.
- `sold_out` out `NUM_PRODUCTS`: bit i is high when stock[i] == 0.

## Operation
- States: IDLE (credit = 0), CREDIT, VEND, CHANGE.
- Reset values:
  - state = IDLE, `credit` = 0, every stock counter = `STOCK_INIT`.
  - `Z`, `Change_given`, `coin_reject`, `sel_reject`, `busy` = 0.
  - `Change_out` = 0, `vend_id` = 0, `sold_out` = 0.
- Request priority in IDLE/CREDIT, same cycle: `cancel` > `sel_valid` > `coin_valid`. A coin presented alongside an accepted cancel or selection is rejected (`coin_reject`).
- Coin acceptance, IDLE/CREDIT:
  - Accept when the code is valid and credit + value <= `CREDIT_MAX`.
  - On accept, credit += value and the next state is CREDIT.
  - Otherwise pulse `coin_reject` and leave credit unchanged.
- Selection, CREDIT only. Accept when all hold: `sel` < `NUM_PRODUCTS`, stock[sel] != 0, and credit >= price[sel].
  - On accept: credit -= price[sel], stock[sel] -= 1, latch `vend_id`, go to VEND.
  - Otherwise pulse `sel_reject` and leave credit and state unchanged.
  - A selection in IDLE also pulses `sel_reject`.
- `cancel`: in CREDIT, go to CHANGE. In IDLE, no effect.
- VEND: lasts exactly one cycle with `Z`=1. The next state is CHANGE if credit > 0, else IDLE.
- CHANGE:
  - Each cycle, `Change_given`=1 and `Change_out` = largest coin in {50,20,10} that is <= credit.
  - Credit is reduced by that coin at the cycle's end.
  - Leave for IDLE on the cycle in which credit reaches 0.
  - Greedy order is therefore 50s, then 20s, then 10s.
- In VEND/CHANGE, every `coin_valid` is rejected, and `sel_valid` and `cancel` are ignored (no reject pulse for either).
- Restock: honoured only in IDLE and only when `restock_id` < `NUM_PRODUCTS`; otherwise it is ignored.
- Arithmetic: credit never exceeds `CREDIT_MAX` and never goes below 0. Stock saturates at 0 (the guard on selection prevents an underflow).

## Timing
- All outputs are registered or decoded from registered state only; no combinational input-to-output path.
- Coin on cycle N: `credit` is updated at N+1, or `coin_reject`=1 at N+1.
- Selection on cycle N: `Z`=1 and the reduced `credit` appear at N+1, and `sold_out` updates at N+1. The first change coin is at N+2.
- Change of value C takes k consecutive cycles, where k = the greedy coin count. `busy` falls in the cycle after the last coin.
- Cancel on cycle N: the first refund coin is at N+1.
- `RESET` asserted in any state, including mid-CHANGE: at the next edge, outputs return to reset values and any remaining credit is discarded.

## Test plan
- Coin 20, coin 20 (back to back), sel=0:
  - `credit` reads 20, then 40.
  - `Z`=1 with `vend_id`=0 for one cycle, then IDLE with `credit`=0 and no `Change_given`.
- Coin 50, coin 50, sel=2 (price 30):
  - `Z` pulse, then `Change_out`=50, then `Change_out`=20 on consecutive cycles.
  - `credit` 70→20→0, then IDLE.
- Coin 10, coin 20, cancel: `Change_out`=20, then 10; `Z` never asserts.
- Set `STOCK_INIT`=1. Coin 50, sel=1 (vend), coin 50, sel=1:
  - The second selection gives `sel_reject`=1, `sold_out`[1]=1, and `credit` stays 50.
  - After cancel and restock_id=1 in IDLE, `sold_out`[1] returns to 0.
- Credit at 180, coin 50: `coin_reject`=1 and `credit` stays 180. Code 11 is also rejected.
- Coin during CHANGE: rejected. Reset during a 3-coin change: next cycle `Change_given`=0, `credit`=0, IDLE.
